reg_bus_master: RTL and testbench
=================================

REG_BUS_MASTER -- requirements
Module: reg_bus_master

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of the register bus address and data.
REQ-002 SHALL have parameter READ_LAT, default 2, cycles from a bus_addr update to a valid bus_rdata sample (range 1..15).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1000, inter-byte idle limit for a partial frame.
REQ-004 SHALL have one clock and one reset: clk is the single clock, and res_n is an asynchronous, active-low reset.
REQ-005 SHALL have ports:
- clk  in  1  clock
- res_n  in  1  async active-low reset
- rx_data  in  8  command stream byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  block accepts a byte
- tx_data  out  8  response byte
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  sink accepts tx_data
- bus_addr  out  DATA_WIDTH  register address to slave
- bus_wdata  out  DATA_WIDTH  write data to slave
- bus_we  out  1  one-cycle write strobe
- bus_rdata  in  DATA_WIDTH  registered slave read data
- err_cnt  out  8  saturating frame-error count

Function
REQ-006 SHALL transfer an rx byte only on a clk edge with rx_valid && rx_ready; SHALL transfer a tx byte only on an edge with tx_valid && tx_ready.
REQ-007 SHALL hold tx_valid and tx_data stable from assertion until the accepting edge.
REQ-008 SHALL implement states IDLE, GET_ADDR, GET_DATA, WRITE, READ_WAIT, RESP. rx_ready is high only in IDLE, GET_ADDR and GET_DATA.
REQ-009 In IDLE, byte 0x57 ('W') or 0x52 ('R') SHALL latch the command and go to GET_ADDR. Any other byte SHALL load response 0x3F, increment err_cnt and go to RESP.
REQ-010 In GET_ADDR, the accepted byte SHALL load bus_addr. A write command then goes to GET_DATA; a read command goes to READ_WAIT.
REQ-011 In GET_DATA, the accepted byte SHALL load bus_wdata and go to WRITE.
REQ-012 WRITE SHALL last exactly one cycle with bus_we=1 and bus_addr/bus_wdata stable. It SHALL then load response 0x4B ('K') and go to RESP.
REQ-013 READ_WAIT SHALL count READ_LAT cycles from entry. On the last cycle it SHALL capture bus_rdata[7:0] as the response and go to RESP.
REQ-014 RESP SHALL assert tx_valid with the response byte and return to IDLE on the accepting edge. A stalled tx_ready SHALL hold RESP indefinitely with no new rx accepted.
REQ-015 bus_we SHALL be 0 in every state except WRITE; bus_addr and bus_wdata SHALL hold their last values outside GET_ADDR and GET_DATA updates.
REQ-016 err_cnt SHALL increment by 1 per error event and saturate at 255 with no wrap.
REQ-017 Minimum write-frame latency, last byte accepted to tx_valid high, SHALL be 2 cycles. For a read frame it SHALL be READ_LAT+1 cycles.

Reset
REQ-018 While res_n=0, all of the following SHALL be forced immediately, independent of clk:
- state=IDLE
- rx_ready=0, tx_valid=0, tx_data=0
- bus_addr=0, bus_wdata=0, bus_we=0
- err_cnt=0
REQ-019 rx_ready SHALL rise on the first clk edge after res_n deasserts.
REQ-020 Reset mid-frame SHALL discard the partial frame without issuing bus_we or a response.

Configuration
REQ-021 Macro REG_BUS_MASTER_TIMEOUT_EN defined: in GET_ADDR or GET_DATA, TIMEOUT_CYCLES consecutive cycles without an accepted byte SHALL abort the frame. The abort SHALL load response 0x54 ('T'), increment err_cnt, and go to RESP. The counter SHALL clear on every accepted byte.
REQ-022 Macro undefined: no timer logic SHALL exist, and partial frames SHALL wait indefinitely.

Structure
REQ-023 Package reg_bus_pkg SHALL hold:
- the state enum
- command constants CMD_WRITE=8'h57 and CMD_READ=8'h52
- response constants RSP_ACK=8'h4B, RSP_ERR=8'h3F and RSP_TMO=8'h54
REQ-024 Sub-module reg_bus_timer (load/clear/expire counter) SHALL be instantiated only under REG_BUS_MASTER_TIMEOUT_EN.

Verification
REQ-025 Send 57,22,05 with tx_ready=1 -> one bus_we pulse with bus_addr=22, bus_wdata=05; then tx 4B.
REQ-026 Preload slave 0x22=07; send 52,22 -> no bus_we; tx 07 appears READ_LAT+1 cycles after the address byte.
REQ-027 Send byte 41 -> tx 3F, err_cnt=1. Then 300 bad bytes -> err_cnt=255, no wrap.
REQ-028 Hold tx_ready=0 for 20 cycles during RESP while rx_valid=1 -> tx_valid/tx_data stable, rx_ready=0; release -> tx accepted, back to IDLE.
REQ-029 Pull res_n low after 57,22 -> outputs zero at once; after release, 52,22 reads normally and no stray bus_we occurs.
REQ-030 With REG_BUS_MASTER_TIMEOUT_EN: send 57, then idle TIMEOUT_CYCLES -> tx 54, err_cnt+1. Without the macro: same stimulus, no tx.

Source files
------------

// File: rtl/reg_bus_pkg.sv
// rtl/reg_bus_pkg.sv - shared states, command/response bytes and helpers for reg_bus_master
package reg_bus_pkg;

   typedef enum logic [2:0] {
      IDLE,
      GET_ADDR,
      GET_DATA,
      WRITE,
      READ_WAIT,
      RESP
   } state_t;

   localparam logic [7:0] CMD_WRITE = 8'h57;
   localparam logic [7:0] CMD_READ  = 8'h52;

   localparam logic [7:0] RSP_ACK   = 8'h4B;
   localparam logic [7:0] RSP_ERR   = 8'h3F;
   localparam logic [7:0] RSP_TMO   = 8'h54;

   // Error counter stops at 255 instead of wrapping back to 0.
   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/reg_bus_timer.sv
// rtl/reg_bus_timer.sv - idle-cycle counter that flags a partial frame as expired
module reg_bus_timer #(
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic clk,
   input  logic res_n,
   input  logic run,
   input  logic clear,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] cnt;

   // An accepted byte in the same cycle wins over expiry.
   assign expired = run && !clear && (cnt == LAST);

   // Count idle cycles while a frame is open; any accepted byte restarts the count.
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         cnt <= '0;
      end else if (!run || clear) begin
         cnt <= '0;
      end else if (cnt != LAST) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/reg_bus_master.sv
// rtl/reg_bus_master.sv - byte-command to register-bus master; REG_BUS_MASTER_TIMEOUT_EN adds partial-frame timeout
module reg_bus_master #(
   parameter int DATA_WIDTH     = 8,
   parameter int READ_LAT       = 2,
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic                  clk,
   input  logic                  res_n,
   input  logic [7:0]            rx_data,
   input  logic                  rx_valid,
   output logic                  rx_ready,
   output logic [7:0]            tx_data,
   output logic                  tx_valid,
   input  logic                  tx_ready,
   output logic [DATA_WIDTH-1:0] bus_addr,
   output logic [DATA_WIDTH-1:0] bus_wdata,
   output logic                  bus_we,
   input  logic [DATA_WIDTH-1:0] bus_rdata,
   output logic [7:0]            err_cnt
);

   import reg_bus_pkg::*;

   localparam logic [3:0] LAT_LAST = 4'(READ_LAT - 1);

   state_t     state;
   logic       is_write;
   logic [3:0] lat_cnt;
   logic       rx_fire;
   logic       tmo_expired;

   assign rx_fire = rx_valid && rx_ready;

`ifdef REG_BUS_MASTER_TIMEOUT_EN
   reg_bus_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timer (
      .clk    (clk),
      .res_n  (res_n),
      .run    ((state == GET_ADDR) || (state == GET_DATA)),
      .clear  (rx_fire),
      .expired(tmo_expired)
   );
`else
   assign tmo_expired = 1'b0;
`endif

   // Frame sequencer: all handshake and bus outputs are registered here.
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         state     <= IDLE;
         is_write  <= 1'b0;
         lat_cnt   <= '0;
         rx_ready  <= 1'b0;
         tx_valid  <= 1'b0;
         tx_data   <= '0;
         bus_addr  <= '0;
         bus_wdata <= '0;
         bus_we    <= 1'b0;
         err_cnt   <= '0;
      end else begin
         bus_we <= 1'b0;
         if (tmo_expired) begin
            tx_data  <= RSP_TMO;
            tx_valid <= 1'b1;
            rx_ready <= 1'b0;
            err_cnt  <= sat_inc(err_cnt);
            state    <= RESP;
         end else begin
            case (state)
               IDLE: begin
                  rx_ready <= 1'b1;
                  if (rx_fire) begin
                     if ((rx_data == CMD_WRITE) || (rx_data == CMD_READ)) begin
                        is_write <= (rx_data == CMD_WRITE);
                        state    <= GET_ADDR;
                     end else begin
                        tx_data  <= RSP_ERR;
                        tx_valid <= 1'b1;
                        rx_ready <= 1'b0;
                        err_cnt  <= sat_inc(err_cnt);
                        state    <= RESP;
                     end
                  end
               end
               GET_ADDR: begin
                  if (rx_fire) begin
                     bus_addr <= DATA_WIDTH'(rx_data);
                     if (is_write) begin
                        state <= GET_DATA;
                     end else begin
                        rx_ready <= 1'b0;
                        lat_cnt  <= '0;
                        state    <= READ_WAIT;
                     end
                  end
               end
               GET_DATA: begin
                  if (rx_fire) begin
                     bus_wdata <= DATA_WIDTH'(rx_data);
                     bus_we    <= 1'b1;
                     rx_ready  <= 1'b0;
                     state     <= WRITE;
                  end
               end
               WRITE: begin
                  tx_data  <= RSP_ACK;
                  tx_valid <= 1'b1;
                  state    <= RESP;
               end
               READ_WAIT: begin
                  if (lat_cnt == LAT_LAST) begin
                     tx_data  <= bus_rdata[7:0];
                     tx_valid <= 1'b1;
                     state    <= RESP;
                  end else begin
                     lat_cnt <= lat_cnt + 4'd1;
                  end
               end
               RESP: begin
                  if (tx_ready) begin
                     tx_valid <= 1'b0;
                     rx_ready <= 1'b1;
                     state    <= IDLE;
                  end
               end
               default: begin
                  rx_ready <= 1'b0;
                  tx_valid <= 1'b0;
                  state    <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_reg_bus_master.sv
// tb/tb_reg_bus_master.sv - directed self-checking bench for reg_bus_master
module tb_reg_bus_master;

   localparam int DW = 8;
   localparam int RL = 2;
   localparam int TO = 1000;

   logic          clk = 1'b0;
   logic          res_n = 1'b1;
   logic [7:0]    rx_data = 8'h00;
   logic          rx_valid = 1'b0;
   logic          rx_ready;
   logic [7:0]    tx_data;
   logic          tx_valid;
   logic          tx_ready = 1'b1;
   logic [DW-1:0] bus_addr;
   logic [DW-1:0] bus_wdata;
   logic          bus_we;
   logic [DW-1:0] bus_rdata = '0;
   logic [7:0]    err_cnt;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int acc_edge = 0;
   int we_count = 0;
   logic [7:0] we_addr = 8'h00;
   logic [7:0] we_wdata = 8'h00;
   logic [7:0] mem [256];

   reg_bus_master #(
      .DATA_WIDTH(DW),
      .READ_LAT(RL),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk      (clk),
      .res_n    (res_n),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ready (rx_ready),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .bus_addr (bus_addr),
      .bus_wdata(bus_wdata),
      .bus_we   (bus_we),
      .bus_rdata(bus_rdata),
      .err_cnt  (err_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Registered slave: READ_LAT=2 means address update edge plus one register stage.
   always @(posedge clk) bus_rdata <= mem[bus_addr];

   always @(negedge clk) begin
      if (bus_we) begin
         we_count = we_count + 1;
         we_addr  = bus_addr;
         we_wdata = bus_wdata;
      end
   end

   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      rx_data  = b;
      rx_valid = 1'b1;
      while (!rx_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!rx_ready) begin
         checks++;
         failures++;
         $display("FAIL send_byte: rx_ready=%0b required 1 within 200 cycles", rx_ready);
      end else begin
         acc_edge = cyc + 1;
      end
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic wait_resp(output logic [7:0] d, output int lat);
      int n;
      n = 0;
      while (!tx_valid && n < 2 * TO + 100) begin
         @(negedge clk);
         n++;
      end
      if (!tx_valid) begin
         checks++;
         failures++;
         $display("FAIL wait_resp: tx_valid=%0b required 1 within bound", tx_valid);
         d   = 8'h00;
         lat = -1;
      end else begin
         d   = tx_data;
         lat = cyc + 1 - acc_edge;
         if (tx_ready) @(negedge clk);
      end
   endtask

   task automatic test_reset();
      res_n = 1'b0;
      #1;
      checks++; if (rx_ready !== 1'b0)  begin failures++; $display("FAIL reset_rx_ready got=%0b want=0", rx_ready); end
      checks++; if (tx_valid !== 1'b0)  begin failures++; $display("FAIL reset_tx_valid got=%0b want=0", tx_valid); end
      checks++; if (tx_data !== 8'h00)  begin failures++; $display("FAIL reset_tx_data got=%h want=00", tx_data); end
      checks++; if (bus_addr !== 8'h00) begin failures++; $display("FAIL reset_bus_addr got=%h want=00", bus_addr); end
      checks++; if (bus_wdata !== 8'h00) begin failures++; $display("FAIL reset_bus_wdata got=%h want=00", bus_wdata); end
      checks++; if (bus_we !== 1'b0)    begin failures++; $display("FAIL reset_bus_we got=%0b want=0", bus_we); end
      checks++; if (err_cnt !== 8'h00)  begin failures++; $display("FAIL reset_err_cnt got=%0d want=0", err_cnt); end
      repeat (3) @(negedge clk);
      res_n = 1'b1;
      @(negedge clk);
      checks++; if (rx_ready !== 1'b1) begin failures++; $display("FAIL reset_release_rx_ready got=%0b want=1", rx_ready); end
   endtask

   task automatic test_write();
      logic [7:0] d;
      int lat;
      int we0;
      we0 = we_count;
      send_byte(8'h57);
      send_byte(8'h22);
      send_byte(8'h05);
      wait_resp(d, lat);
      checks++; if (we_count - we0 !== 1) begin failures++; $display("FAIL write_we_pulses got=%0d want=1", we_count - we0); end
      checks++; if (we_addr !== 8'h22)   begin failures++; $display("FAIL write_addr got=%h want=22", we_addr); end
      checks++; if (we_wdata !== 8'h05)  begin failures++; $display("FAIL write_wdata got=%h want=05", we_wdata); end
      checks++; if (d !== 8'h4B)         begin failures++; $display("FAIL write_resp got=%h want=4B", d); end
      checks++; if (lat !== 2)           begin failures++; $display("FAIL write_latency got=%0d want=2", lat); end
   endtask

   task automatic test_read();
      logic [7:0] d;
      int lat;
      int we0;
      we0 = we_count;
      mem[8'h22] = 8'h07;
      send_byte(8'h52);
      send_byte(8'h22);
      wait_resp(d, lat);
      checks++; if (we_count !== we0) begin failures++; $display("FAIL read_no_we got=%0d want=%0d", we_count, we0); end
      checks++; if (d !== 8'h07)      begin failures++; $display("FAIL read_data got=%h want=07", d); end
      checks++; if (lat !== RL + 1)   begin failures++; $display("FAIL read_latency got=%0d want=%0d", lat, RL + 1); end
   endtask

   task automatic test_stall();
      logic [7:0] d;
      int lat;
      int bad_valid;
      int bad_data;
      int bad_ready;
      bad_valid = 0;
      bad_data  = 0;
      bad_ready = 0;
      tx_ready = 1'b0;
      send_byte(8'h57);
      send_byte(8'h33);
      send_byte(8'hA5);
      wait_resp(d, lat);
      rx_valid = 1'b1;
      rx_data  = 8'h52;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (tx_valid !== 1'b1) bad_valid++;
         if (tx_data !== 8'h4B) bad_data++;
         if (rx_ready !== 1'b0) bad_ready++;
      end
      checks++; if (bad_valid !== 0) begin failures++; $display("FAIL stall_tx_valid drops=%0d want=0", bad_valid); end
      checks++; if (bad_data !== 0)  begin failures++; $display("FAIL stall_tx_data changes=%0d want=0", bad_data); end
      checks++; if (bad_ready !== 0) begin failures++; $display("FAIL stall_rx_ready highs=%0d want=0", bad_ready); end
      rx_valid = 1'b0;
      tx_ready = 1'b1;
      @(negedge clk);
      checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL stall_release_tx_valid got=%0b want=0", tx_valid); end
      checks++; if (rx_ready !== 1'b1) begin failures++; $display("FAIL stall_release_rx_ready got=%0b want=1", rx_ready); end
      checks++; if (we_addr !== 8'h33 || we_wdata !== 8'hA5) begin failures++; $display("FAIL stall_write got=%h/%h want=33/A5", we_addr, we_wdata); end
   endtask

   task automatic test_timeout();
      logic [7:0] d;
      int lat;
      logic [7:0] e0;
      e0 = err_cnt;
      send_byte(8'h57);
`ifdef REG_BUS_MASTER_TIMEOUT_EN
      wait_resp(d, lat);
      checks++; if (d !== 8'h54)          begin failures++; $display("FAIL timeout_resp got=%h want=54", d); end
      checks++; if (lat !== TO + 1)       begin failures++; $display("FAIL timeout_latency got=%0d want=%0d", lat, TO + 1); end
      checks++; if (err_cnt !== e0 + 8'd1) begin failures++; $display("FAIL timeout_err_cnt got=%0d want=%0d", err_cnt, e0 + 8'd1); end
`else
      begin
         int seen;
         seen = 0;
         for (int i = 0; i < TO + 20; i++) begin
            @(negedge clk);
            if (tx_valid) seen++;
         end
         checks++; if (seen !== 0) begin failures++; $display("FAIL no_timeout_tx cycles_valid=%0d want=0", seen); end
         send_byte(8'h44);
         send_byte(8'h66);
         wait_resp(d, lat);
         checks++; if (d !== 8'h4B)       begin failures++; $display("FAIL no_timeout_resume got=%h want=4B", d); end
         checks++; if (err_cnt !== e0)    begin failures++; $display("FAIL no_timeout_err_cnt got=%0d want=%0d", err_cnt, e0); end
         checks++; if (we_addr !== 8'h44 || we_wdata !== 8'h66) begin failures++; $display("FAIL no_timeout_write got=%h/%h want=44/66", we_addr, we_wdata); end
      end
`endif
   endtask

   task automatic test_reset_mid();
      logic [7:0] d;
      int lat;
      int we0;
      send_byte(8'h57);
      send_byte(8'h22);
      we0 = we_count;
      res_n = 1'b0;
      #1;
      checks++; if (bus_addr !== 8'h00) begin failures++; $display("FAIL midreset_bus_addr got=%h want=00", bus_addr); end
      checks++; if (rx_ready !== 1'b0)  begin failures++; $display("FAIL midreset_rx_ready got=%0b want=0", rx_ready); end
      checks++; if (err_cnt !== 8'h00)  begin failures++; $display("FAIL midreset_err_cnt got=%0d want=0", err_cnt); end
      @(negedge clk);
      res_n = 1'b1;
      @(negedge clk);
      mem[8'h22] = 8'h07;
      send_byte(8'h52);
      send_byte(8'h22);
      wait_resp(d, lat);
      checks++; if (d !== 8'h07)      begin failures++; $display("FAIL midreset_read got=%h want=07", d); end
      checks++; if (we_count !== we0) begin failures++; $display("FAIL midreset_stray_we got=%0d want=%0d", we_count, we0); end
   endtask

   task automatic test_errors();
      logic [7:0] d;
      int lat;
      int bad_rsp;
      bad_rsp = 0;
      send_byte(8'h41);
      wait_resp(d, lat);
      checks++; if (d !== 8'h3F)       begin failures++; $display("FAIL err_resp got=%h want=3F", d); end
      checks++; if (err_cnt !== 8'd1)  begin failures++; $display("FAIL err_cnt_first got=%0d want=1", err_cnt); end
      for (int i = 0; i < 300; i++) begin
         send_byte((i % 2) ? 8'h41 : 8'hFF);
         wait_resp(d, lat);
         if (d !== 8'h3F) bad_rsp++;
         if (i == 252) begin
            checks++; if (err_cnt !== 8'd254) begin failures++; $display("FAIL err_cnt_254 got=%0d want=254", err_cnt); end
         end
         if (i == 253) begin
            checks++; if (err_cnt !== 8'd255) begin failures++; $display("FAIL err_cnt_255 got=%0d want=255", err_cnt); end
         end
      end
      checks++; if (bad_rsp !== 0)       begin failures++; $display("FAIL err_resp_loop wrong=%0d want=0", bad_rsp); end
      checks++; if (err_cnt !== 8'd255)  begin failures++; $display("FAIL err_cnt_saturate got=%0d want=255", err_cnt); end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'(i ^ 8'h5A);
      #3;
      test_reset();
      test_write();
      test_read();
      test_stall();
      test_timeout();
      test_reset_mid();
      test_errors();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
